// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: SPI peripheral giving the controller read/write access to a
// NUM_REGS x DATA_W register file. Frame (MSB first): R/W bit (1 = write),
// ADDR_W address bits, DATA_W data bits. CPHA is 0; CPOL selects the idle level.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no frame in progress, waiting for cs falling edge
// CMD     | shifting in R/W bit and address
// WDATA   | shifting in write data; commit on the last bit
// RDATA   | shifting read data out on cipo
// DONE    | frame complete, sclk ignored until cs rises
module spi_regfile_rw #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         cs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int          FRAME_LEN  = 1 + ADDR_W + DATA_W;
  localparam int          CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic        CPOL_L     = (CPOL != 0);
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, cs_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic                   sclk_s, copi_s, cs_s;
  logic                   lead_edge, trail_edge, cs_fall, cs_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      cmd_q, cmd_d;       // R/W bit plus leading address bits
  logic [DATA_W-2:0]      data_q, data_d;     // write shift-in / read shift-out
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   cipo_q, cipo_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   frame_err_q, frame_err_d;
  logic                   wr_en;

  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [ADDR_W:0]        cmd_full;
  logic [DATA_W-1:0]      data_full;
  logic [DATA_W-1:0]      rd_word;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS_U);
  endfunction

  // Synchronise the SPI pins into clk and keep one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL_L}};
      copi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= CPOL_L;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s     = copi_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign lead_edge  = (sclk_hist_q == CPOL_L) && (sclk_s != CPOL_L);
  assign trail_edge = (sclk_hist_q != CPOL_L) && (sclk_s == CPOL_L);
  assign cs_fall    = cs_hist_q && !cs_s;
  assign cs_rise    = !cs_hist_q && cs_s;

  assign cmd_full  = {cmd_q, copi_s};
  assign data_full = {data_q, copi_s};

  // Read mux for the address just completed; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_full[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      cipo_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      cipo_q      <= cipo_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and datapath logic; a cs falling edge restarts the frame from any state
  // and masks a leading edge seen in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    addr_d      = addr_q;
    cipo_d      = cipo_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = frame_err_q;
    wr_en       = 1'b0;

    if (cs_fall) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      cmd_d   = '0;
      data_d  = '0;
      cipo_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cipo_d = 1'b0;
        end
        ST_CMD: begin
          if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            cipo_d      = 1'b0;
          end else if (lead_edge) begin
            if (cnt_q == CNT_W'(ADDR_W)) begin
              addr_d = cmd_full[ADDR_W-1:0];
              cnt_d  = '0;
              if (cmd_full[ADDR_W]) begin
                state_d = ST_WDATA;
                data_d  = '0;
              end else begin
                state_d = ST_RDATA;
                data_d  = rd_word[DATA_W-2:0];
                cipo_d  = rd_word[DATA_W-1];
              end
            end else begin
              cmd_d = cmd_full[ADDR_W-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WDATA: begin
          if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            cipo_d      = 1'b0;
          end else if (lead_edge) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = ST_DONE;
              if (addr_in_range(addr_q)) begin
                wr_en       = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                frame_err_d = 1'b0;
              end else begin
                frame_err_d = 1'b1;
              end
            end else begin
              data_d = data_full[DATA_W-2:0];
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RDATA: begin
          // cnt counts data bits already sampled by the controller; the trailing edge
          // that follows the last address bit must not shift.
          if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            cipo_d      = 1'b0;
          end else if (lead_edge) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d     = ST_DONE;
              cipo_d      = 1'b0;
              frame_err_d = !addr_in_range(addr_q);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (trail_edge && (cnt_q != '0)) begin
            cipo_d = data_q[DATA_W-2];
            data_d = data_q << 1;
          end
        end
        ST_DONE: begin
          cipo_d = 1'b0;
          if (cs_rise) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cipo_d  = 1'b0;
        end
      endcase
    end
  end

  // Register file: changes only on a committed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (addr_q == ADDR_W'(i))) regs_q[i] <= data_full;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = cipo_q;
  assign cipo_oe   = !cs_s;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Bench for spi_regfile_rw: two instances (default build and a CPOL=1, 4-bit address,
// 16-bit data build) driven by a timed SPI controller task. Expected writes and read
// data are queued at issue time and checked by separate monitor processes.
module tb_spi_regfile_rw;

  localparam int HALF = 60;   // sclk half period in ns (6 clk cycles)

  logic        clk, rst;
  logic        sclk_v [2];
  logic        copi_v [2];
  logic        cs_v   [2];
  logic        cipo0, cipo1, oe0, oe1;
  logic [39:0] regs0;
  logic [79:0] regs1;
  logic        strb0, strb1;
  logic [6:0]  wa0;
  logic [3:0]  wa1;
  logic        fe0, fe1;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_wr0 [$];   // {addr[15:0], data[15:0]}
  logic [31:0] exp_wr1 [$];
  logic [31:0] rd_exp  [$];
  logic [31:0] rd_act  [$];

  spi_regfile_rw dut0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .copi(copi_v[0]), .cs(cs_v[0]),
    .cipo(cipo0), .cipo_oe(oe0), .regs_flat(regs0), .wr_strobe(strb0),
    .wr_addr(wa0), .frame_err(fe0)
  );

  spi_regfile_rw #(.NUM_REGS(5), .ADDR_W(4), .DATA_W(16), .CPOL(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .copi(copi_v[1]), .cs(cs_v[1]),
    .cipo(cipo1), .cipo_oe(oe1), .regs_flat(regs1), .wr_strobe(strb1),
    .wr_addr(wa1), .frame_err(fe1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    logic [31:0] e;
    int a;
    if (strb0 === 1'b1) begin
      if (exp_wr0.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr0_unexpected: strobe at addr %0h, none queued", wa0);
      end else begin
        e = exp_wr0.pop_front();
        a = int'(e[31:16]);
        chk("wr0_addr", 128'(wa0), 128'(e[31:16]));
        chk("wr0_data", 128'(regs0[a*8 +: 8]), 128'(e[7:0]));
      end
    end
    if (strb1 === 1'b1) begin
      if (exp_wr1.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr1_unexpected: strobe at addr %0h, none queued", wa1);
      end else begin
        e = exp_wr1.pop_front();
        a = int'(e[31:16]);
        chk("wr1_addr", 128'(wa1), 128'(e[31:16]));
        chk("wr1_data", 128'(regs1[a*16 +: 16]), 128'(e[15:0]));
      end
    end
  end

  // Read monitor: pairs each collected read word with its queued expectation.
  always @(negedge clk) begin
    logic [31:0] r;
    if (rd_act.size() != 0) begin
      r = rd_act.pop_front();
      if (rd_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got %0h, none queued", r);
      end else begin
        chk("rd_data", 128'(r), 128'(rd_exp.pop_front()));
      end
    end
  end

  // One SPI frame on bus b, MSB first; stops after stop_after bits (abort if < n).
  // cipo is sampled just before each leading edge, as a CPHA=0 controller does.
  task automatic spi_frame(input int b, input logic [31:0] bits, input int n,
                           input int stop_after, input int gap, output logic [31:0] rd);
    logic cp;
    cp = (b == 1);
    rd = '0;
    cs_v[b] = 1'b0;
    for (int i = 0; i < stop_after; i++) begin
      copi_v[b] = bits[n-1-i];
      #HALF;
      rd = {rd[30:0], (b == 0) ? cipo0 : cipo1};
      sclk_v[b] = ~cp;
      #HALF;
      sclk_v[b] = cp;
    end
    #HALF;
    cs_v[b]   = 1'b1;
    copi_v[b] = 1'b0;
    #gap;
  endtask

  initial begin
    logic [31:0] rd;
    rst = 1'b1;
    sclk_v[0] = 1'b0; copi_v[0] = 1'b0; cs_v[0] = 1'b1;
    sclk_v[1] = 1'b1; copi_v[1] = 1'b0; cs_v[1] = 1'b1;
    #52;
    chk("rst_regs0", 128'(regs0), 128'(0));
    chk("rst_cipo0", 128'(cipo0), 128'(0));
    chk("rst_oe0",   128'(oe0),   128'(0));
    chk("rst_strb0", 128'(strb0), 128'(0));
    chk("rst_wa0",   128'(wa0),   128'(0));
    chk("rst_fe0",   128'(fe0),   128'(0));
    chk("rst_regs1", 128'(regs1), 128'(0));
    rst = 1'b0;
    #50;

    // 1: write reg4 = 0x80
    exp_wr0.push_back({16'd4, 16'h0080});
    spi_frame(0, {16'd0, 1'b1, 7'd4, 8'h80}, 16, 16, 300, rd);
    chk("t1_regs", 128'(regs0), 128'(40'h80_0000_0000));
    chk("t1_fe",   128'(fe0),   128'(0));
    chk("t1_oe_idle",   128'(oe0),   128'(0));
    chk("t1_cipo_idle", 128'(cipo0), 128'(0));

    // 2: write reg2 = 0xA5, read back addr 2 and the top register addr 4
    exp_wr0.push_back({16'd2, 16'h00A5});
    spi_frame(0, {16'd0, 1'b1, 7'd2, 8'hA5}, 16, 16, 300, rd);
    rd_exp.push_back(32'h0000_00A5);
    spi_frame(0, {16'd0, 1'b0, 7'd2, 8'h00}, 16, 16, 300, rd);
    rd_act.push_back({24'd0, rd[7:0]});
    chk("t2_regs", 128'(regs0), 128'(40'h80_00A5_0000));
    chk("t2_fe",   128'(fe0),   128'(0));
    rd_exp.push_back(32'h0000_0080);
    spi_frame(0, {16'd0, 1'b0, 7'd4, 8'h00}, 16, 16, 300, rd);
    rd_act.push_back({24'd0, rd[7:0]});
    chk("t2_cipo_after", 128'(cipo0), 128'(0));

    // 3: write out-of-range addr 9, then a good write clears frame_err
    spi_frame(0, {16'd0, 1'b1, 7'd9, 8'h3C}, 16, 16, 300, rd);
    chk("t3_regs_oor", 128'(regs0), 128'(40'h80_00A5_0000));
    chk("t3_fe_oor",   128'(fe0),   128'(1));
    exp_wr0.push_back({16'd1, 16'h0011});
    spi_frame(0, {16'd0, 1'b1, 7'd1, 8'h11}, 16, 16, 300, rd);
    chk("t3_regs_good", 128'(regs0), 128'(40'h80_00A5_1100));
    chk("t3_fe_good",   128'(fe0),   128'(0));

    // 4: abort a write to reg1 after 10 bits
    spi_frame(0, {16'd0, 1'b1, 7'd1, 8'h77}, 16, 10, 300, rd);
    chk("t4_regs_abort", 128'(regs0), 128'(40'h80_00A5_1100));
    chk("t4_fe_abort",   128'(fe0),   128'(1));
    chk("t4_oe_abort",   128'(oe0),   128'(0));
    exp_wr0.push_back({16'd0, 16'h00FF});
    spi_frame(0, {16'd0, 1'b1, 7'd0, 8'hFF}, 16, 16, 300, rd);
    chk("t4_regs_after", 128'(regs0), 128'(40'h80_00A5_11FF));
    chk("t4_fe_after",   128'(fe0),   128'(0));

    // out-of-range read returns zero and flags frame_err
    rd_exp.push_back(32'h0000_0000);
    spi_frame(0, {16'd0, 1'b0, 7'd7, 8'h00}, 16, 16, 300, rd);
    rd_act.push_back({24'd0, rd[7:0]});
    chk("oor_read_fe", 128'(fe0), 128'(1));

    // 5: reset in the middle of a frame
    cs_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      copi_v[0] = i[0];
      #HALF; sclk_v[0] = 1'b1;
      #HALF; sclk_v[0] = 1'b0;
    end
    chk("t5_oe_active", 128'(oe0), 128'(1));
    rst = 1'b1;
    #20;
    chk("t5_regs_rst", 128'(regs0), 128'(0));
    chk("t5_cipo_rst", 128'(cipo0), 128'(0));
    chk("t5_oe_rst",   128'(oe0),   128'(0));
    chk("t5_fe_rst",   128'(fe0),   128'(0));
    cs_v[0] = 1'b1; copi_v[0] = 1'b0;
    #20;
    rst = 1'b0;
    #100;
    exp_wr0.push_back({16'd3, 16'h005A});
    spi_frame(0, {16'd0, 1'b1, 7'd3, 8'h5A}, 16, 16, 300, rd);
    chk("t5_regs_after", 128'(regs0), 128'(40'h00_5A00_0000));
    chk("t5_wa_after",   128'(wa0),   128'(3));

    // 6: CPOL=1, 4-bit address, 16-bit data
    exp_wr1.push_back({16'd3, 16'hBEEF});
    spi_frame(1, {11'd0, 1'b1, 4'd3, 16'hBEEF}, 21, 21, 300, rd);
    rd_exp.push_back(32'h0000_BEEF);
    spi_frame(1, {11'd0, 1'b0, 4'd3, 16'h0000}, 21, 21, 300, rd);
    rd_act.push_back({16'd0, rd[15:0]});
    chk("t6_fe", 128'(fe1), 128'(0));
    exp_wr1.push_back({16'd0, 16'h1234});
    spi_frame(1, {11'd0, 1'b1, 4'd0, 16'h1234}, 21, 21, 2*HALF, rd);
    exp_wr1.push_back({16'd4, 16'hCAFE});
    spi_frame(1, {11'd0, 1'b1, 4'd4, 16'hCAFE}, 21, 21, 300, rd);
    chk("t6_regs", 128'(regs1), 128'(80'hCAFE_BEEF_0000_0000_1234));
    chk("t6_wa",   128'(wa1),   128'(4));
    chk("t6_regs0_untouched", 128'(regs0), 128'(40'h00_5A00_0000));

    #500;
    chk("wr0_queue_drained", 128'(exp_wr0.size()), 128'(0));
    chk("wr1_queue_drained", 128'(exp_wr1.size()), 128'(0));
    chk("rd_queue_drained",  128'(rd_exp.size()),  128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
